// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM/direction types and default playfield geometry for the pong ball datapath.
package pong_pkg;

    typedef enum logic {SERVE = 1'b0, PLAY  = 1'b1} state_e;
    typedef enum logic {LEFT  = 1'b0, RIGHT = 1'b1} dirX_e;
    typedef enum logic {UP    = 1'b0, DOWN  = 1'b1} dirY_e;

    localparam int DEF_H_CNT_WID    = 10;
    localparam int DEF_V_CNT_WID    = 10;
    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_BALL_PIXSIZE = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_LX    = 16;
    localparam int DEF_PADDLE_RX    = 624;
    localparam int DEF_SPEED        = 2;
    localparam int DEF_MAX_SPEED    = 6;
    localparam int DEF_SERVE_FRAMES = 60;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/paddle_hit_checker.sv
// paddle_hit_checker: combinational vertical-overlap test between the ball and one paddle.
module paddle_hit_checker
    import pong_pkg::*;
#(
    parameter int V_CNT_WID    = DEF_V_CNT_WID,
    parameter int BALL_PIXSIZE = DEF_BALL_PIXSIZE,
    parameter int PADDLE_H     = DEF_PADDLE_H
) (
    input  logic [V_CNT_WID-1:0] ballY,
    input  logic [V_CNT_WID-1:0] padY,
    output logic                 overlap
);

    localparam int VW = V_CNT_WID + 1;
    localparam logic [VW-1:0] BALL_SZ = VW'(BALL_PIXSIZE);
    localparam logic [VW-1:0] PAD_SZ  = VW'(PADDLE_H);

    logic [VW-1:0] ballBot;
    logic [VW-1:0] padBot;

    // One extra bit so paddles near the bottom edge cannot wrap past zero.
    assign ballBot = {1'b0, ballY} + BALL_SZ;
    assign padBot  = {1'b0, padY} + PAD_SZ;
    assign overlap = (ballBot > {1'b0, padY}) && ({1'b0, ballY} < padBot);

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: pong ball FSM (SERVE/PLAY) with wall/paddle bounces and point pulses.
// Optional macro BALL_SPEEDUP_EN: each paddle hit adds 1 to speed (capped), SERVE restores it.
module ball_motion_ctrl
    import pong_pkg::*;
#(
    parameter int H_CNT_WID    = DEF_H_CNT_WID,
    parameter int V_CNT_WID    = DEF_V_CNT_WID,
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int BALL_PIXSIZE = DEF_BALL_PIXSIZE,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_LX    = DEF_PADDLE_LX,
    parameter int PADDLE_RX    = DEF_PADDLE_RX,
    parameter int SPEED        = DEF_SPEED,
    parameter int MAX_SPEED    = DEF_MAX_SPEED,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frameTick,
    input  logic                 pause,
    input  logic [V_CNT_WID-1:0] leftPaddleY,
    input  logic [V_CNT_WID-1:0] rightPaddleY,
    output logic [H_CNT_WID-1:0] ballX,
    output logic [V_CNT_WID-1:0] ballY,
    output logic                 scoreLeft,
    output logic                 scoreRight,
    output logic                 ballActive
);

    localparam int HW    = H_CNT_WID + 1;
    localparam int VW    = V_CNT_WID + 1;
    localparam int SPD_W = $clog2(maxInt(SPEED, MAX_SPEED) + 1);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [HW-1:0]    X_CTR    = HW'((SCREEN_W - BALL_PIXSIZE) / 2);
    localparam logic [VW-1:0]    Y_CTR    = VW'((SCREEN_H - BALL_PIXSIZE) / 2);
    localparam logic [VW-1:0]    Y_MAX    = VW'(SCREEN_H - BALL_PIXSIZE);
    localparam logic [HW-1:0]    X_LHIT   = HW'(PADDLE_LX);
    localparam logic [HW-1:0]    X_RHIT   = HW'(PADDLE_RX - BALL_PIXSIZE);
    localparam logic [HW-1:0]    X_RLIM   = HW'(PADDLE_RX);
    localparam logic [HW-1:0]    X_SIZE   = HW'(BALL_PIXSIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_e           state;
    dirX_e            dirX, dirXNext;
    dirY_e            dirY, dirYNext;
    logic [CNT_W-1:0] frameCnt;
    logic [SPD_W-1:0] speed;
    logic [HW-1:0]    xCur, xNext, spdX;
    logic [VW-1:0]    yCur, yNext, spdY;
    logic             overlapLeft, overlapRight;
    logic             paddleHit, missLeft, missRight, tickOk;

    assign tickOk     = frameTick && !pause;
    assign ballActive = (state == PLAY);
    assign xCur       = {1'b0, ballX};
    assign yCur       = {1'b0, ballY};
    assign spdX       = HW'(speed);
    assign spdY       = VW'(speed);

    paddle_hit_checker #(
        .V_CNT_WID(V_CNT_WID), .BALL_PIXSIZE(BALL_PIXSIZE), .PADDLE_H(PADDLE_H)
    ) uLeftHit (
        .ballY(ballY), .padY(leftPaddleY), .overlap(overlapLeft)
    );

    paddle_hit_checker #(
        .V_CNT_WID(V_CNT_WID), .BALL_PIXSIZE(BALL_PIXSIZE), .PADDLE_H(PADDLE_H)
    ) uRightHit (
        .ballY(ballY), .padY(rightPaddleY), .overlap(overlapRight)
    );

    always_comb begin
        xNext     = xCur;
        yNext     = yCur;
        dirXNext  = dirX;
        dirYNext  = dirY;
        paddleHit = 1'b0;
        missLeft  = 1'b0;
        missRight = 1'b0;

        if (dirX == LEFT) begin
            if (xCur < X_LHIT + spdX) begin
                if (overlapLeft) begin
                    xNext     = X_LHIT;
                    dirXNext  = RIGHT;
                    paddleHit = 1'b1;
                end else begin
                    missLeft  = 1'b1;
                end
            end else begin
                xNext = xCur - spdX;
            end
        end else begin
            if (xCur + X_SIZE + spdX > X_RLIM) begin
                if (overlapRight) begin
                    xNext     = X_RHIT;
                    dirXNext  = LEFT;
                    paddleHit = 1'b1;
                end else begin
                    missRight = 1'b1;
                end
            end else begin
                xNext = xCur + spdX;
            end
        end

        if (dirY == UP) begin
            if (yCur < spdY) begin
                yNext    = '0;
                dirYNext = DOWN;
            end else begin
                yNext = yCur - spdY;
            end
        end else if (yCur + spdY >= Y_MAX) begin
            yNext    = Y_MAX;
            dirYNext = UP;
        end else begin
            yNext = yCur + spdY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SERVE;
            frameCnt   <= '0;
            ballX      <= X_CTR[H_CNT_WID-1:0];
            ballY      <= Y_CTR[V_CNT_WID-1:0];
            dirX       <= RIGHT;
            dirY       <= DOWN;
            scoreLeft  <= 1'b0;
            scoreRight <= 1'b0;
        end else begin
            scoreLeft  <= 1'b0;
            scoreRight <= 1'b0;
            if (tickOk) begin
                if (state == SERVE) begin
                    if (frameCnt == CNT_LAST) begin
                        frameCnt <= '0;
                        state    <= PLAY;
                    end else begin
                        frameCnt <= frameCnt + 1'b1;
                    end
                end else if (missLeft || missRight) begin
                    // A point wins over the vertical step; dirY survives into the next serve.
                    state      <= SERVE;
                    ballX      <= X_CTR[H_CNT_WID-1:0];
                    ballY      <= Y_CTR[V_CNT_WID-1:0];
                    dirX       <= missLeft ? LEFT : RIGHT;
                    scoreRight <= missLeft;
                    scoreLeft  <= missRight;
                end else begin
                    ballX <= xNext[HW-1] ? '1 : xNext[H_CNT_WID-1:0];
                    ballY <= yNext[VW-1] ? '1 : yNext[V_CNT_WID-1:0];
                    dirX  <= dirXNext;
                    dirY  <= dirYNext;
                end
            end
        end
    end

`ifdef BALL_SPEEDUP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            speed <= SPD_W'(SPEED);
        end else if (tickOk && state == PLAY) begin
            if (missLeft || missRight)
                speed <= SPD_W'(SPEED);
            else if (paddleHit && speed < SPD_W'(MAX_SPEED))
                speed <= speed + 1'b1;
        end
    end
`else
    assign speed = SPD_W'(SPEED);
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: randomized scenario bench for ball_motion_ctrl against a frame-level model.
module tb_ball_motion_ctrl;

    localparam int SW = 640, SH = 480, SZ = 8, PH = 64, LX = 16, RX = 624;
    localparam int SPD = 2, MAXS = 6, SF = 60;
    localparam int XC = (SW - SZ) / 2, YC = (SH - SZ) / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0, frameTick = 1'b0, pause = 1'b0;
    logic [9:0] leftPaddleY = '0, rightPaddleY = '0;
    logic [9:0] ballX, ballY;
    logic       scoreLeft, scoreRight, ballActive;

    int total = 0, bad = 0;

    // Frame-level model of the game.
    bit mPlay, mDx, mDy, mSL, mSR, mHitLeft, mTopBounce;
    int mCnt, mX, mY, mSpd, lp, rp;

    logic [22:0] got, exp;

    always #5 clk = ~clk;

    ball_motion_ctrl dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .pause(pause),
        .leftPaddleY(leftPaddleY), .rightPaddleY(rightPaddleY),
        .ballX(ballX), .ballY(ballY), .scoreLeft(scoreLeft), .scoreRight(scoreRight),
        .ballActive(ballActive)
    );

    function automatic bit overlaps(input int y, input int p);
        return (y + SZ > p) && (y < p + PH);
    endfunction

    task automatic modelReset();
        mPlay = 0; mCnt = 0; mX = XC; mY = YC; mDx = 1; mDy = 1; mSpd = SPD;
        mSL = 0; mSR = 0;
    endtask

    task automatic modelStep();
        int nx, ny;
        bit hit, pass;
        mSL = 0; mSR = 0; mHitLeft = 0; mTopBounce = 0;
        if (!mPlay) begin
            mCnt++;
            if (mCnt == SF) begin mCnt = 0; mPlay = 1; end
            return;
        end
        hit = 0; pass = 0; nx = mX;
        if (mDx == 0) begin
            if (mX < LX + mSpd) begin
                if (overlaps(mY, lp)) begin nx = LX; mDx = 1; hit = 1; mHitLeft = 1; end
                else begin pass = 1; mSR = 1; end
            end else nx = mX - mSpd;
        end else begin
            if (mX + SZ + mSpd > RX) begin
                if (overlaps(mY, rp)) begin nx = RX - SZ; mDx = 0; hit = 1; end
                else begin pass = 1; mSL = 1; end
            end else nx = mX + mSpd;
        end
        if (pass) begin
            mPlay = 0; mX = XC; mY = YC; mSpd = SPD;
            return;
        end
        if (mDy == 0) begin
            if (mY < mSpd) begin ny = 0; mDy = 1; mTopBounce = 1; end
            else ny = mY - mSpd;
        end else if (mY + mSpd >= SH - SZ) begin ny = SH - SZ; mDy = 0; end
        else ny = mY + mSpd;
        mX = nx; mY = ny;
`ifdef BALL_SPEEDUP_EN
        if (hit && mSpd < MAXS) mSpd++;
`else
        if (hit) mSpd = mSpd;
`endif
    endtask

    function automatic bit willScore();
        if (!mPlay) return 0;
        if (mDx == 0) return (mX < LX + mSpd) && !overlaps(mY, lp);
        return (mX + SZ + mSpd > RX) && !overlaps(mY, rp);
    endfunction

    // mode 0: paddle overlaps ball, 1: paddle clear of ball, other: mixed incl. edge cases
    function automatic int pickPad(input int mode);
        int p;
        case (mode)
            0: p = mY + SZ - 1 - int'($urandom_range(0, SZ + PH - 2));
            1: p = (mY < SH / 2) ? SH - 80 : 0;
            default: begin
                case ($urandom_range(0, 3))
                    0: p = mY + SZ - 1 - int'($urandom_range(0, SZ + PH - 2));
                    1: p = mY + SZ;
                    2: p = mY - PH;
                    default: p = int'($urandom_range(0, SH - PH));
                endcase
            end
        endcase
        if (p < 0) p = 0;
        return p;
    endfunction

    task automatic setPaddles(input int mode);
        lp = pickPad(mode);
        rp = pickPad(mode);
        leftPaddleY  = 10'(lp);
        rightPaddleY = 10'(rp);
    endtask

    task automatic tick(input bit p, input int idle);
        repeat (idle) @(posedge clk);
        @(negedge clk);
        frameTick = 1'b1; pause = p;
        @(posedge clk); #1;
        frameTick = 1'b0; pause = 1'b0;
        if (p) begin mSL = 0; mSR = 0; end
        else modelStep();
        got = {ballX, ballY, ballActive, scoreLeft, scoreRight};
        exp = {10'(mX), 10'(mY), mPlay, mSL, mSR};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; frameTick = 1'b1; pause = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        total++; if (ballX !== 10'(XC)) begin bad++; $display("FAIL reset ballX: got %0d want %0d", ballX, XC); end
        total++; if (ballY !== 10'(YC)) begin bad++; $display("FAIL reset ballY: got %0d want %0d", ballY, YC); end
        total++; if (ballActive !== 1'b0) begin bad++; $display("FAIL reset ballActive: got %b want 0", ballActive); end
        total++; if ({scoreLeft, scoreRight} !== 2'b00) begin bad++; $display("FAIL reset scores: got %b want 00", {scoreLeft, scoreRight}); end
        @(negedge clk);
        rst = 1'b0; frameTick = 1'b0;
    endtask

    task automatic test_serve();
        for (int i = 1; i <= SF; i++) begin
            setPaddles(0);
            tick(1'b0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL serve tick %0d: got %h want %h", i, got, exp); end
        end
        total++; if (ballActive !== 1'b1) begin bad++; $display("FAIL serve active after %0d ticks: got %b want 1", SF, ballActive); end
        setPaddles(0);
        tick(1'b0, 0);
        total++;
        if (ballX !== 10'd318 || ballY !== 10'd238) begin
            bad++; $display("FAIL first play step: got x=%0d y=%0d want x=318 y=238", ballX, ballY);
        end
    endtask

    task automatic test_wall_bounce();
        bit seen = 0;
        for (int i = 0; i < 800 && !seen; i++) begin
            setPaddles(0);
            tick(1'b0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL wall tick %0d: got %h want %h", i, got, exp); end
            seen = mTopBounce;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL wall top bounce: got none want one within 800 ticks"); end
        setPaddles(0);
        tick(1'b0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL wall after top: got %h want %h", got, exp); end
    endtask

    task automatic test_paddle_hit();
        bit seen = 0;
        for (int i = 0; i < 800 && !seen; i++) begin
            setPaddles(0);
            tick(1'b0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL hit tick %0d: got %h want %h", i, got, exp); end
            seen = mHitLeft;
        end
        total++;
        if (!seen || ballX !== 10'(LX) || scoreRight !== 1'b0) begin
            bad++; $display("FAIL left paddle hit: got x=%0d sr=%b want x=%0d sr=0", ballX, scoreRight, LX);
        end
        for (int i = 0; i < 3; i++) begin
            setPaddles(0);
            tick(1'b0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL after hit %0d: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_miss_score();
        bit seen = 0;
        for (int i = 0; i < 800 && !seen; i++) begin
            setPaddles(1);
            tick(1'b0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL miss tick %0d: got %h want %h", i, got, exp); end
            seen = mSL | mSR;
        end
        total++;
        if (!seen || (scoreLeft ^ scoreRight) !== 1'b1 || ballX !== 10'(XC) || ballY !== 10'(YC) || ballActive !== 1'b0) begin
            bad++; $display("FAIL score event: got sl=%b sr=%b x=%0d y=%0d act=%b want one pulse x=%0d y=%0d act=0",
                            scoreLeft, scoreRight, ballX, ballY, ballActive, XC, YC);
        end
        @(posedge clk); #1;
        total++;
        if ({scoreLeft, scoreRight} !== 2'b00) begin bad++; $display("FAIL score pulse width: got %b want 00", {scoreLeft, scoreRight}); end
    endtask

    task automatic test_pause();
        logic [9:0] hx, hy;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL pause serve %0d: got %h want %h", i, got, exp); end
        end
        for (int i = 0; i < SF + 1; i++) begin
            setPaddles(0);
            tick(1'b0, 0);
            total++;
            if (got !== exp) begin bad++; $display("FAIL resume serve %0d: got %h want %h", i, got, exp); end
        end
        hx = ballX; hy = ballY;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 0);
            total++;
            if (ballX !== hx || ballY !== hy || ballActive !== 1'b1) begin
                bad++; $display("FAIL pause play %0d: got x=%0d y=%0d want x=%0d y=%0d", i, ballX, ballY, hx, hy);
            end
        end
        setPaddles(0);
        tick(1'b0, 0);
        total++;
        if (got !== exp) begin bad++; $display("FAIL resume play: got %h want %h", got, exp); end
    endtask

    task automatic test_reset_score();
        bit ready = 0;
        for (int i = 0; i < 1000 && !ready; i++) begin
            setPaddles(1);
            if (willScore()) ready = 1;
            else tick(1'b0, 0);
        end
        total++;
        if (!ready) begin bad++; $display("FAIL reset/score setup: got no scoring frame want one"); end
        @(negedge clk);
        rst = 1'b1; frameTick = 1'b1;
        @(posedge clk); #1;
        modelReset();
        total++;
        if ({scoreLeft, scoreRight} !== 2'b00 || ballX !== 10'(XC) || ballY !== 10'(YC) || ballActive !== 1'b0) begin
            bad++; $display("FAIL reset over score: got sl=%b sr=%b x=%0d y=%0d act=%b want 0 0 %0d %0d 0",
                            scoreLeft, scoreRight, ballX, ballY, ballActive, XC, YC);
        end
        @(negedge clk);
        rst = 1'b0; frameTick = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({scoreLeft, scoreRight} !== 2'b00) begin bad++; $display("FAIL late score after reset: got %b want 00", {scoreLeft, scoreRight}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            setPaddles(int'($urandom_range(0, 4)));
            tick($urandom_range(0, 5) == 0, int'($urandom_range(0, 2)));
            total++;
            if (got !== exp) begin bad++; $display("FAIL random tick %0d: got %h want %h", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_wall_bounce();
        test_paddle_hit();
        test_miss_score();
        test_pause();
        test_reset_score();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 SHALL have parameter H_CNT_WID, default 10: width of X coordinates.
REQ-002 SHALL have parameter V_CNT_WID, default 10: width of Y coordinates.
REQ-003 SHALL have parameters SCREEN_W=640 and SCREEN_H=480: playfield size in pixels.
REQ-004 SHALL have parameter BALL_PIXSIZE, default 8: ball edge length in pixels.
REQ-005 SHALL have parameters PADDLE_H=64, PADDLE_LX=16 (left paddle's right edge X) and PADDLE_RX=624 (right paddle's left edge X).
REQ-006 SHALL have parameters SPEED=2 (pixels per frame per axis), MAX_SPEED=6 and SERVE_FRAMES=60 (serve wait).
REQ-007 SHALL have ports: clk input 1 (sole clock); rst input 1 (synchronous, active-high).
REQ-008 SHALL have ports: frameTick input 1 (one-cycle pulse per frame); pause input 1 (freeze motion).
REQ-009 SHALL have ports: leftPaddleY and rightPaddleY, input, V_CNT_WID (paddle top edge Y).
REQ-010 SHALL have ports: ballX output H_CNT_WID; ballY output V_CNT_WID (ball top-left corner).
REQ-011 SHALL have ports: scoreLeft and scoreRight, output 1 each (one-cycle point pulses); ballActive output 1 (high in PLAY).

Function
REQ-012 SHALL implement FSM states SERVE and PLAY; frameTick SHALL be ignored in either state while pause=1.
REQ-013 In SERVE: ballX=(SCREEN_W-BALL_PIXSIZE)/2, ballY=(SCREEN_H-BALL_PIXSIZE)/2; the frame counter SHALL increment per accepted frameTick; on the SERVE_FRAMES-th tick it SHALL clear and the FSM SHALL enter PLAY.
REQ-014 In PLAY: the position SHALL update exactly one cycle after an accepted frameTick (registered), and at no other time.
REQ-015 Vertical: moving up, if ballY<speed then ballY=0 and dirY=down, else ballY-=speed; moving down, if ballY+speed>=SCREEN_H-BALL_PIXSIZE then ballY=SCREEN_H-BALL_PIXSIZE and dirY=up, else ballY+=speed.
REQ-016 Paddle overlap SHALL be true when ballY+BALL_PIXSIZE>padY and ballY<padY+PADDLE_H, evaluated on the pre-update ballY.
REQ-017 Moving left with ballX<PADDLE_LX+speed: on overlap, ballX=PADDLE_LX and dirX=right; otherwise scoreRight pulses for one cycle and the FSM enters SERVE with dirX=left.
REQ-018 Moving right with ballX+BALL_PIXSIZE+speed>PADDLE_RX: on overlap, ballX=PADDLE_RX-BALL_PIXSIZE and dirX=left; otherwise scoreLeft pulses and the FSM enters SERVE with dirX=right.
REQ-019 Otherwise ballX SHALL move by speed in dirX.
REQ-020 Simultaneous horizontal and vertical bounce in one frame: both SHALL apply.
REQ-021 A score SHALL override the vertical update; the ball SHALL recentre and dirY SHALL be kept.
REQ-022 All arithmetic SHALL be carried one bit wider than the operand width, so that sums cannot wrap.
REQ-023 scoreLeft and scoreRight SHALL never be high in the same cycle.

Reset
REQ-024 On rst, the block SHALL set: state=SERVE, counter=0, ballX/ballY=centre, dirX=right, dirY=down, speed=SPEED, scores=0, ballActive=0.
REQ-025 rst SHALL take precedence over frameTick and pause in the same cycle, including when rst is asserted mid-PLAY.

Configuration
REQ-026 With BALL_SPEEDUP_EN defined, each paddle hit SHALL increment speed by 1, saturating at MAX_SPEED, and entry to SERVE SHALL restore speed to SPEED.
REQ-027 Without BALL_SPEEDUP_EN, speed SHALL remain constant at SPEED and MAX_SPEED SHALL be unused.

Structure
REQ-028 The state enum, the direction typedef (LEFT/RIGHT, UP/DOWN) and the default geometry constants SHALL live in the shared package pong_pkg.
REQ-029 Paddle overlap SHALL be one combinational sub-module, paddle_hit_checker, instantiated twice (left and right paddles).

Verification
REQ-030 Bench: after rst, 60 frameTicks -> ballActive=1 after the 60th; next tick -> ballX=318, ballY=238 one cycle later.
REQ-031 Bench: ballY=1 moving up, tick -> ballY=0, dirY=down; next tick -> ballY=2.
REQ-032 Bench: ballX=17 moving left, leftPaddleY=200, ballY=230, tick -> ballX=16, dirX=right, no score pulse; with BALL_SPEEDUP_EN, speed=3.
REQ-033 Bench: same case with leftPaddleY=300 -> scoreRight high exactly one cycle, state SERVE, ballX=316, ballY=236.
REQ-034 Bench: pause=1 for 10 frameTicks in PLAY -> ballX/ballY unchanged; in SERVE -> counter unchanged.
REQ-035 Bench: rst asserted in the same cycle as a scoring frameTick -> no score pulse, all outputs at reset values.
